shift_add_multiplier: RTL and testbench
=======================================

# shift_add_multiplier

Sequential unsigned shift-and-add multiplier, the multiply-direction counterpart of the team's restoring divider. Takes two W-bit operands on a start pulse and iterates one multiplier bit per clock. Returns the 2W-bit product, a W-bit result with an overflow flag, and a one-cycle done pulse. Sits beside the divider in the arithmetic unit and shares its start/done handshake style.

## Interface
- W, 10, operand width; product is 2W bits
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset (asserted at 0)
- start  in  1  request; sampled only in IDLE or DONE
- Ain  in  W  multiplicand, captured on the accepting edge
- Bin  in  W  multiplier, captured on the accepting edge
- busy  out  1  high while in CALC
- done  out  1  one-cycle pulse, high exactly during the DONE cycle
- prod  out  2W  full product; valid from DONE until the next accepted start
- out  out  W  low W bits of product (see Configuration)
- ovf  out  1  high when prod[2W-1:W] != 0; valid with prod

## Operation
- Registers:
  - M: W bits, multiplicand.
  - ACC: W bits, high half.
  - Q: W bits, multiplier shifting into the low half.
  - C: 1-bit carry.
  - cnt: $clog2(W+1) bits.
- FSM states: IDLE, CALC, DONE.
- IDLE, start=1:
  - M<=Ain, Q<=Bin, ACC<=0, C<=0, cnt<=0.
  - Go to CALC.
- CALC, each edge:
  - If Q[0]=1, {C,ACC} = ACC+M as a (W+1)-bit sum; otherwise {C,ACC} = {0,ACC}.
  - Shift {C,ACC,Q} right by one, so ACC[W-1]<=C and Q[W-1]<=ACC[0].
  - cnt<=cnt+1. When cnt==W-1, go to DONE.
- DONE:
  - done=1. prod={ACC,Q} is held.
  - start=1 behaves exactly as start in IDLE (back-to-back accept); otherwise go to IDLE.
- IDLE holds prod/out/ovf from the last operation.
- start is ignored during CALC; the operation in flight is unaffected.
- No early termination: zero operands still take W iterations.
- Arithmetic is unsigned. The 2W-bit product never wraps. Overflow concerns only the W-bit out.

## Timing
- Reset (rst=0, asynchronous, at any time including mid-CALC):
  - State=IDLE; busy=0, done=0.
  - prod=0, out=0, ovf=0, cnt=0, M/ACC/Q/C=0.
- The first edge after rst deasserts is a normal IDLE edge.
- Latency: start sampled at edge 0. CALC iterations occur on edges 1..W. done is high in the cycle after edge W, i.e. W cycles after acceptance (10 for W=10).
- Throughput: one product per W+1 cycles with back-to-back start.
- busy is high from the cycle after edge 0 through the cycle after edge W-1.
- prod/out/ovf may toggle during CALC; they are only guaranteed while done=1 and in the following IDLE.
- All outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

## Configuration
- MULT_SAT_EN undefined: out = prod[W-1:0] (truncation); ovf still reports overflow.
- MULT_SAT_EN defined: out = {W{1'b1}} when ovf=1, otherwise prod[W-1:0].
- prod and ovf are identical in both builds.

## Structure
- Package mult_pkg holds:
  - The default W.
  - The state enum (IDLE, CALC, DONE).
  - The counter width constant.
- Sub-module mult_datapath holds M, ACC, C, Q, the (W+1)-bit adder, the shift logic, cnt and the ovf decode. It takes control strobes (load, step) from the FSM and returns cnt_last.
- shift_add_multiplier holds the FSM and the MULT_SAT_EN output mux.

## Test plan
- 5*3: Ain=5, Bin=3, start 1 cycle. Required: done 10 cycles later, prod=15, out=15, ovf=0, busy high for 10 cycles.
- 1023*1023: Required: prod=0xFF801, ovf=1, out=0x001 without MULT_SAT_EN and 0x3FF with it.
- 0*777 and 777*0: Required: prod=0, ovf=0, and still a 10-cycle latency.
- start pulsed mid-CALC with new operands (e.g. 2*2 while 7*9 is running). Required: result 63; second request ignored; done pulses once.
- start held high across DONE (37*41 then 100*11). Required: prod 1517 then 1100, with done pulses 11 cycles apart.
- rst=0 asserted asynchronously mid-CALC. Required: busy, done, prod, ovf at 0 immediately; after release, a fresh 12*12 gives 144.

Source files
------------

// File: rtl/mult_pkg.sv
// mult_pkg: shared constants and types for the shift-and-add multiplier.
//   W_DEF    default operand width (product is 2*W_DEF bits)
//   state_e  controller states
//   cnt_w()  iteration counter width for a given operand width
//   CNT_W    counter width at the default operand width
package mult_pkg;

  localparam int W_DEF = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must reach W-1; sized like the divider's so both share layout.
  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = $clog2(W_DEF + 1);

endpackage

// File: rtl/shift_add_multiplier_if.sv
// shift_add_multiplier_if: start/done handshake plus operand/result bus.
//   start, Ain, Bin             request side (driven by master)
//   busy, done, prod, out, ovf  response side (driven by slave)
interface shift_add_multiplier_if
  import mult_pkg::*;
#(
  parameter int W = W_DEF
);
  logic           start;
  logic [W-1:0]   Ain;
  logic [W-1:0]   Bin;
  logic           busy;
  logic           done;
  logic [2*W-1:0] prod;
  logic [W-1:0]   out;
  logic           ovf;

  modport master (output start, Ain, Bin, input busy, done, prod, out, ovf);
  modport slave  (input start, Ain, Bin, output busy, done, prod, out, ovf);
endinterface

// File: rtl/mult_datapath.sv
// mult_datapath: operand registers, (W+1)-bit adder, right shift and
// iteration counter of the shift-and-add multiplier.
//   clk, rst       clock, async active-low reset
//   load           capture a_in/b_in, clear ACC/C/cnt
//   step           one add-and-shift iteration
//   a_in, b_in     multiplicand / multiplier
//   cnt_last       this step is the final (W-th) iteration
//   prod           {ACC,Q}
//   ovf            high half of the product is non-zero
module mult_datapath
  import mult_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int CW = cnt_w(W)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic [W-1:0]   a_in,
  input  logic [W-1:0]   b_in,
  output logic           cnt_last,
  output logic [2*W-1:0] prod,
  output logic           ovf
);

  logic [W-1:0]  m_q,   m_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [W-1:0]  q_q,   q_d;
  logic          c_q,   c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W:0]    sum;

  // Partial sum keeps the carry so the 2W-bit product never wraps.
  assign sum = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);

  always_comb begin
    m_d   = m_q;
    acc_d = acc_q;
    q_d   = q_q;
    c_d   = c_q;
    cnt_d = cnt_q;
    if (load) begin
      m_d   = a_in;
      q_d   = b_in;
      acc_d = '0;
      c_d   = 1'b0;
      cnt_d = '0;
    end else if (step) begin
      // {C,ACC,Q} >> 1 with {C,ACC} = sum: carry enters ACC MSB,
      // ACC LSB enters Q MSB, consumed multiplier bit drops out.
      c_d   = sum[W];
      acc_d = sum[W:1];
      q_d   = {sum[0], q_q[W-1:1]};
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q   <= '0;
      acc_q <= '0;
      q_q   <= '0;
      c_q   <= 1'b0;
      cnt_q <= '0;
    end else begin
      m_q   <= m_d;
      acc_q <= acc_d;
      q_q   <= q_d;
      c_q   <= c_d;
      cnt_q <= cnt_d;
    end
  end

  assign cnt_last = (cnt_q == CW'(W - 1));
  assign prod     = {acc_q, q_q};
  assign ovf      = |acc_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned W x W -> 2W multiplier, one
// multiplier bit per clock, start/done handshake.
//   clk   rising-edge clock
//   rst   asynchronous reset, active low
//   bus   shift_add_multiplier_if.slave (start, Ain, Bin, busy, done,
//         prod, out, ovf)
// Build option: MULT_SAT_EN -- when defined, out saturates to all-ones on
// overflow; otherwise out is the truncated low half of prod.
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  shift_add_multiplier_if.slave bus
);

  state_e         state_q, state_d;
  logic           load, step, cnt_last, ovf;
  logic [2*W-1:0] prod;

  mult_datapath #(.W(W)) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .a_in     (bus.Ain),
    .b_in     (bus.Bin),
    .cnt_last (cnt_last),
    .prod     (prod),
    .ovf      (ovf)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // start is only looked at in IDLE/DONE, so a request during CALC is dropped.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        load    = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        step = 1'b1;
        if (cnt_last) state_d = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = (state_q == CALC);
  assign bus.done = (state_q == DONE);
  assign bus.prod = prod;
  assign bus.ovf  = ovf;

`ifdef MULT_SAT_EN
  assign bus.out = ovf ? {W{1'b1}} : prod[W-1:0];
`else
  assign bus.out = prod[W-1:0];
`endif

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: directed self-checking bench. Expected results
// are pushed to a scoreboard queue when a start is driven and popped when
// done is observed.
module tb_shift_add_multiplier;
  import mult_pkg::*;

  localparam int W = W_DEF;

  typedef struct packed {
    logic [2*W-1:0] prod;
    logic [W-1:0]   out;
    logic           ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  shift_add_multiplier_if #(.W(W)) bus ();

  shift_add_multiplier #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.prod = (2*W)'(a) * (2*W)'(b);
    e.ovf  = (e.prod[2*W-1:W] != '0);
`ifdef MULT_SAT_EN
    e.out  = e.ovf ? {W{1'b1}} : e.prod[W-1:0];
`else
    e.out  = e.prod[W-1:0];
`endif
    return e;
  endfunction

  // Drive a request so that it is sampled at the next rising edge; return
  // 1 time unit after that edge.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    @(negedge clk);
    bus.Ain   = a;
    bus.Bin   = b;
    bus.start = 1'b1;
    sb.push_back(model(a, b));
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  // Wait (bounded) for done; exp_n is the falling edge on which done must
  // first be seen, busy must be high on every falling edge before it.
  task automatic wait_done(input string tag, input int exp_n);
    int   n      = 0;
    int   busy_n = 0;
    bit   seen   = 1'b0;
    exp_t e;
    for (int i = 1; i <= exp_n + 5; i++) begin
      @(negedge clk);
      if (bus.done) begin
        n    = i;
        seen = 1'b1;
        break;
      end
      if (bus.busy) busy_n++;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_latency"},   64'(n),        64'(exp_n));
      check({tag, "_busy_cyc"},  64'(busy_n),   64'(exp_n - 1));
      check({tag, "_busy_low"},  64'(bus.busy), 64'd0);
    end
    check({tag, "_sb_entry"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      if (seen) begin
        check({tag, "_prod"}, 64'(bus.prod), 64'(e.prod));
        check({tag, "_out"},  64'(bus.out),  64'(e.out));
        check({tag, "_ovf"},  64'(bus.ovf),  64'(e.ovf));
      end
    end
  endtask

  initial begin
    int done_n;
    bus.start = 1'b0;
    bus.Ain   = '0;
    bus.Bin   = '0;
    rst       = 1'b0;

    // Reset state
    #12;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_prod", 64'(bus.prod), 64'd0);
    check("rst_out",  64'(bus.out),  64'd0);
    check("rst_ovf",  64'(bus.ovf),  64'd0);
    @(negedge clk);
    rst = 1'b1;

    // 5*3, then the result must hold in IDLE
    start_op(10'd5, 10'd3, 1'b0);
    wait_done("5x3", W + 1);
    @(negedge clk);
    check("5x3_idle_done", 64'(bus.done), 64'd0);
    check("5x3_idle_prod", 64'(bus.prod), 64'd15);
    check("5x3_idle_out",  64'(bus.out),  64'd15);

    // Full-scale operands: overflow of the W-bit result
    start_op(10'd1023, 10'd1023, 1'b0);
    wait_done("1023x1023", W + 1);
    check("1023x1023_prod_const", 64'(bus.prod), 64'h0FF801);

    // Zero operands still take W iterations
    start_op(10'd0, 10'd777, 1'b0);
    wait_done("0x777", W + 1);
    start_op(10'd777, 10'd0, 1'b0);
    wait_done("777x0", W + 1);

    // start mid-CALC with new operands is ignored
    start_op(10'd7, 10'd9, 1'b0);
    repeat (3) @(negedge clk);
    bus.Ain   = 10'd2;
    bus.Bin   = 10'd2;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("7x9_mid", W + 1 - 3);
    check("7x9_mid_prod_const", 64'(bus.prod), 64'd63);
    done_n = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done) done_n++;
    end
    check("7x9_mid_extra_done", 64'(done_n), 64'd0);
    check("7x9_mid_sb_empty",   64'(sb.size()), 64'd0);

    // start held high across DONE: back-to-back accept, 11 cycles apart
    start_op(10'd37, 10'd41, 1'b1);
    bus.Ain = 10'd100;
    bus.Bin = 10'd11;
    sb.push_back(model(10'd100, 10'd11));
    wait_done("b2b_37x41", W + 1);
    check("b2b_37x41_prod_const", 64'(bus.prod), 64'd1517);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done("b2b_100x11", W + 1);
    check("b2b_100x11_prod_const", 64'(bus.prod), 64'd1100);

    // Asynchronous reset mid-CALC, then a fresh operation
    start_op(10'd50, 10'd60, 1'b0);
    repeat (4) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'd0);
    check("arst_done", 64'(bus.done), 64'd0);
    check("arst_prod", 64'(bus.prod), 64'd0);
    check("arst_out",  64'(bus.out),  64'd0);
    check("arst_ovf",  64'(bus.ovf),  64'd0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    start_op(10'd12, 10'd12, 1'b0);
    wait_done("12x12", W + 1);
    check("12x12_prod_const", 64'(bus.prod), 64'd144);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
